// File: rtl/sr_column_streamer.sv
`default_nettype none
// ============================================================================
// Module      : sr_column_streamer
// Description : Streams an 11x11 search region column by column into the SAD
//               datapath and tags each completed 4x4 candidate with {v,h}.
//               Optional build macro SR_STALL_EN adds a pipeline-freeze input.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_column_streamer #(
  parameter int PIX_W  = 8,
  parameter int COLS   = 11,
  parameter int VSTEPS = 8,
  parameter int BLK    = 4,
  localparam int c_dw    = PIX_W * COLS,
  localparam int c_col_w = $clog2(COLS),
  localparam int c_v_w   = $clog2(VSTEPS),
  localparam int c_h_w   = $clog2(COLS - BLK + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [c_col_w-1:0]       mem_addr,
  input  logic [c_dw-1:0]          mem_rdata,
  output logic [c_dw-1:0]          can_b,
  output logic                     can_valid,
  output logic                     cand_valid,
  output logic [c_v_w+c_h_w-1:0]   sr_addressRead
`ifdef SR_STALL_EN
  ,
  input  logic                     stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [c_col_w-1:0]        r_c;
  logic [c_v_w-1:0]          r_v;
  logic                      r_drain;
  logic                      w_stall;
  logic                      w_last_read;

  logic                      r_p1_valid;
  logic [c_v_w-1:0]          r_p1_v;
  logic [c_col_w-1:0]        r_p1_c;
  logic                      w_is_cand;
  logic [c_h_w-1:0]          w_h;
  logic [c_dw-1:0]           w_shifted;

  logic [c_dw-1:0]           r_can_b;
  logic                      r_can_valid;
  logic                      r_cand_valid;
  logic [c_v_w+c_h_w-1:0]    r_sr_addr;

  // Stall only freezes an active sweep; idle and done phases ignore it.
`ifdef SR_STALL_EN
  assign w_stall = stall && ((r_state == S_RUN) || (r_state == S_DRAIN));
`else
  assign w_stall = 1'b0;
`endif

  assign w_last_read = (r_c == c_col_w'(COLS - 1)) && (r_v == c_v_w'(VSTEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        mem_rd_en = !w_stall;
        if (!w_stall && w_last_read) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!w_stall && r_drain) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Column/row-pass counters; they advance only on an issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c     <= '0;
      r_v     <= '0;
      r_drain <= 1'b0;
    end else begin
      r_drain <= (r_state == S_DRAIN) ? (r_drain | !w_stall) : 1'b0;
      if (mem_rd_en) begin
        if (r_c == c_col_w'(COLS - 1)) begin
          r_c <= '0;
          r_v <= (r_v == c_v_w'(VSTEPS - 1)) ? '0 : r_v + 1'b1;
        end else begin
          r_c <= r_c + 1'b1;
        end
      end
    end
  end

  assign mem_addr  = r_c;
  assign w_is_cand = (r_p1_c >= c_col_w'(BLK - 1));
  assign w_h       = c_h_w'(r_p1_c - c_col_w'(BLK - 1));
  assign w_shifted = mem_rdata << (PIX_W * int'(r_p1_v));

  // Stage 1 tracks the read in flight; stage 2 forms the beat once data lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_valid   <= 1'b0;
      r_p1_v       <= '0;
      r_p1_c       <= '0;
      r_can_b      <= '0;
      r_can_valid  <= 1'b0;
      r_cand_valid <= 1'b0;
      r_sr_addr    <= '0;
    end else if (!w_stall) begin
      r_p1_valid   <= mem_rd_en;
      r_p1_v       <= r_v;
      r_p1_c       <= r_c;
      r_can_valid  <= r_p1_valid;
      r_cand_valid <= r_p1_valid && w_is_cand;
      if (r_p1_valid) begin
        r_can_b   <= w_shifted;
        r_sr_addr <= {r_p1_v, (w_is_cand ? w_h : c_h_w'(0))};
      end
    end
  end

  assign can_b          = r_can_b;
  assign can_valid      = r_can_valid && !w_stall;
  assign cand_valid     = r_cand_valid && !w_stall;
  assign sr_addressRead = r_sr_addr;

endmodule
`default_nettype wire

// File: tb/tb_sr_column_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_column_streamer
// Description : Scoreboard bench for sr_column_streamer (SR_STALL_EN optional).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_column_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_rd_en, can_valid, cand_valid;
  logic [3:0]  mem_addr;
  logic [87:0] mem_rdata = '0;
  logic [87:0] can_b;
  logic [5:0]  sr_addressRead;
`ifdef SR_STALL_EN
  logic        stall = 1'b0;
`endif

  sr_column_streamer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .can_b          (can_b),
    .can_valid      (can_valid),
    .cand_valid     (cand_valid),
    .sr_addressRead (sr_addressRead)
`ifdef SR_STALL_EN
    ,
    .stall          (stall)
`endif
  );

  always #5 clk = ~clk;

  logic [87:0] mem [0:10];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic [87:0] b;
    logic        cv;
    logic [5:0]  a;
  } beat_t;

  beat_t sb[$];
  beat_t e;
  int    checks = 0;
  int    errors = 0;
  int    beat_cnt = 0;
  int    cand_cnt = 0;
  bit    hand_chk = 1'b0;

  task automatic chk(input string nm, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_mem(input int pat);
    for (int c = 0; c < 11; c++)
      for (int r = 0; r < 11; r++)
        mem[c][87-8*r -: 8] = (pat == 0) ? (8'(16*c) ^ 8'(r)) : 8'(37*c + 11*r + 5);
  endtask

  // Output row r of a beat is source row r+v of the column, zero past row 10.
  function automatic beat_t model(input int v, input int c);
    beat_t m;
    m.b = '0;
    for (int r = 0; r < 11; r++)
      if (r + v <= 10) m.b[87-8*r -: 8] = mem[c][87-8*(r+v) -: 8];
    m.cv = (c >= 3);
    m.a  = {3'(v), (c >= 3) ? 3'(c-3) : 3'd0};
    return m;
  endfunction

  task automatic push_sweep();
    for (int v = 0; v < 8; v++)
      for (int c = 0; c < 11; c++)
        sb.push_back(model(v, c));
  endtask

  always @(negedge clk) begin
    if (rst_n && can_valid) begin
`ifdef SR_STALL_EN
      if (stall) chk("valid_during_stall", 1, 0);
`endif
      if (sb.size() == 0) begin
        chk("unexpected_beat", {80'd0, 2'd0, sr_addressRead}, 88'd0);
      end else begin
        e = sb.pop_front();
        chk("can_b", can_b, e.b);
        chk("cand_valid", cand_valid, e.cv);
        chk("sr_addressRead", sr_addressRead, e.a);
        if (hand_chk && beat_cnt == 14) begin
          chk("beat14_row0", can_b[87:80], 8'h31);
          chk("beat14_addr", sr_addressRead, 6'b001_000);
        end
        if (cand_valid) cand_cnt++;
        beat_cnt++;
      end
    end
  end

  task automatic drive(input int n, input int pa, input int pb, input int slo, input int shi);
    start = (n == pa) || (n == pb);
`ifdef SR_STALL_EN
    stall = (n >= slo) && (n <= shi);
`else
    if (slo > shi) start = start;
`endif
  endtask

  task automatic sweep(input int pa, input int pb, input int slo, input int shi, input int exp_done);
    int n;
    @(posedge clk); #1;
    push_sweep();
    beat_cnt = 0;
    cand_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    drive(n, pa, pb, slo, shi);
    chk("busy_cycle1", busy, 1);
    chk("rd_en_cycle1", mem_rd_en, 1);
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      drive(n, pa, pb, slo, shi);
    end
    chk("done_cycle", n, exp_done);
    chk("busy_in_done", busy, 0);
    @(posedge clk); #1;
    drive(0, 1, 1, 1, 0);
    start = 1'b0;
    chk("done_single_pulse", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("beat_count", beat_cnt, 88);
    chk("cand_count", cand_cnt, 64);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    bit rd_seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rd_seen |= mem_rd_en;
    end
    chk("idle_rd_seen", rd_seen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_can_valid", can_valid, 0);
    chk("rst_cand_valid", cand_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_can_b", can_b, 0);
    chk("rst_sr_addr", sr_addressRead, 0);

    // Basic sweep with the hand-checked pattern.
    fill_mem(0);
    hand_chk = 1'b1;
    sweep(0, 0, 1, 0, 91);

    // Extra start pulses during a sweep are ignored.
    sweep(5, 40, 1, 0, 91);
    hand_chk = 1'b0;

    // Second data pattern.
    fill_mem(1);
    sweep(0, 0, 1, 0, 91);

    // Reset in the middle of a sweep.
    fill_mem(0);
    @(posedge clk); #1;
    push_sweep();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_en", mem_rd_en, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_can_valid", can_valid, 0);
    chk("midrst_cand_valid", cand_valid, 0);
    chk("midrst_can_b", can_b, 0);
    chk("midrst_sr_addr", sr_addressRead, 0);
    sb.delete();
    beat_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_busy", busy, 0);
    chk("postrst_no_beats", beat_cnt, 0);
    hand_chk = 1'b1;
    sweep(0, 0, 1, 0, 91);
    hand_chk = 1'b0;

`ifdef SR_STALL_EN
    hand_chk = 1'b1;
    sweep(0, 0, 20, 24, 96);
    hand_chk = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
